// File: rtl/call_ctrl.sv
// Call/return sequencer driving an external return-address stack and the PC mux.
// Every output is registered; the stack answers a pop strobe one cycle later on pop_data.
module call_ctrl #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              pc,
    input  logic [AW-1:0]              target,
    input  logic [AW-1:0]              pop_data,
    input  logic                       err_clr,
    output logic                       pushsignal,
    output logic                       popsignal,
    output logic [AW-1:0]              push,
    output logic                       pc_sel,
    output logic [AW-1:0]              pc_next,
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       ovf,
    output logic                       unf
);
    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALL  = 3'd1,
        POP   = 3'd2,
        WAIT  = 3'd3,
        REDIR = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            pushsignal_q, pushsignal_d;
    logic            popsignal_q, popsignal_d;
    logic [AW-1:0]   push_q, push_d;
    logic            pc_sel_q, pc_sel_d;
    logic [AW-1:0]   pc_next_q, pc_next_d;
    logic            stall_q, stall_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    always_comb begin
        state_d      = state_q;
        pushsignal_d = 1'b0;
        popsignal_d  = 1'b0;
        pc_sel_d     = 1'b0;
        push_d       = push_q;
        pc_next_d    = pc_next_q;
        depth_d      = depth_q;
        // A new error in the same cycle as err_clr overrides the clear below.
        ovf_d        = err_clr ? 1'b0 : ovf_q;
        unf_d        = err_clr ? 1'b0 : unf_q;

        unique case (state_q)
            IDLE: begin
                if (ret) begin
                    if (depth_q != '0) begin
                        state_d     = POP;
                        popsignal_d = 1'b1;
                        depth_d     = depth_q - DW'(1);
                    end else begin
                        unf_d = 1'b1;
                    end
                end else if (call) begin
                    if (depth_q < FULL) begin
                        state_d      = CALL;
                        pushsignal_d = 1'b1;
                        pc_sel_d     = 1'b1;
                        push_d       = pc + AW'(1);
                        pc_next_d    = target;
                        depth_d      = depth_q + DW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            CALL:  state_d = IDLE;
            POP:   state_d = WAIT;
            WAIT: begin
                state_d   = REDIR;
                pc_sel_d  = 1'b1;
                pc_next_d = pop_data;
            end
            REDIR: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pushsignal_q <= 1'b0;
            popsignal_q  <= 1'b0;
            push_q       <= '0;
            pc_sel_q     <= 1'b0;
            pc_next_q    <= '0;
            stall_q      <= 1'b0;
            depth_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pushsignal_q <= pushsignal_d;
            popsignal_q  <= popsignal_d;
            push_q       <= push_d;
            pc_sel_q     <= pc_sel_d;
            pc_next_q    <= pc_next_d;
            stall_q      <= stall_d;
            depth_q      <= depth_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign pushsignal = pushsignal_q;
    assign popsignal  = popsignal_q;
    assign push       = push_q;
    assign pc_sel     = pc_sel_q;
    assign pc_next    = pc_next_q;
    assign stall      = stall_q;
    assign depth      = depth_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
endmodule

// File: tb/tb_call_ctrl.sv
// Directed bench for call_ctrl: calls, returns, overflow/underflow, priority,
// address wrap, busy-ignore and asynchronous mid-operation reset.
module tb_call_ctrl;
    localparam int AW = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] target = '0;
    logic [AW-1:0] pop_data = '0;
    logic          err_clr = 1'b0;
    logic          pushsignal, popsignal, pc_sel, stall, ovf, unf;
    logic [AW-1:0] push, pc_next;
    logic [3:0]    depth;

    int n_checks = 0;
    int n_errors = 0;

    call_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .pc(pc),
        .target(target), .pop_data(pop_data), .err_clr(err_clr),
        .pushsignal(pushsignal), .popsignal(popsignal), .push(push),
        .pc_sel(pc_sel), .pc_next(pc_next), .stall(stall), .depth(depth),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_pushsignal", 32'(pushsignal), 32'd0);
        chk("rst_popsignal",  32'(popsignal),  32'd0);
        chk("rst_pc_sel",     32'(pc_sel),     32'd0);
        chk("rst_stall",      32'(stall),      32'd0);
        chk("rst_depth",      32'(depth),      32'd0);
        chk("rst_flags",      32'({ovf, unf}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single call
        pc = 10'h010; target = 10'h200; call = 1'b1;
        tick(); call = 1'b0;
        chk("call_pushsignal", 32'(pushsignal), 32'd1);
        chk("call_push",       32'(push),       32'h011);
        chk("call_pc_sel",     32'(pc_sel),     32'd1);
        chk("call_pc_next",    32'(pc_next),    32'h200);
        chk("call_depth",      32'(depth),      32'd1);
        chk("call_stall",      32'(stall),      32'd1);
        chk("call_popsignal",  32'(popsignal),  32'd0);
        tick();
        chk("call_done_strobes", 32'({pushsignal, pc_sel, stall}), 32'd0);

        // Single return
        pop_data = 10'h011; ret = 1'b1;
        tick(); ret = 1'b0;
        chk("ret_c1_popsignal", 32'(popsignal), 32'd1);
        chk("ret_c1_stall",     32'(stall),     32'd1);
        chk("ret_c1_pc_sel",    32'(pc_sel),    32'd0);
        chk("ret_c1_depth",     32'(depth),     32'd0);
        tick();
        chk("ret_c2_pop_sel_stall", 32'({popsignal, pc_sel, stall}), 32'b001);
        tick();
        chk("ret_c3_pc_sel",    32'(pc_sel),    32'd1);
        chk("ret_c3_pc_next",   32'(pc_next),   32'h011);
        chk("ret_c3_stall",     32'(stall),     32'd1);
        tick();
        chk("ret_done", 32'({pc_sel, stall}), 32'd0);

        // Underflow
        ret = 1'b1;
        tick(); ret = 1'b0;
        chk("unf_flag",      32'(unf),       32'd1);
        chk("unf_no_pop",    32'(popsignal), 32'd0);
        chk("unf_no_stall",  32'(stall),     32'd0);
        chk("unf_depth",     32'(depth),     32'd0);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        chk("unf_cleared",   32'(unf),       32'd0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            pc = AW'(i * 4); target = 10'h100; call = 1'b1;
            tick(); call = 1'b0;
            tick();
        end
        chk("full_depth", 32'(depth), 32'd8);
        call = 1'b1;
        tick(); call = 1'b0;
        chk("ovf_flag",       32'(ovf),        32'd1);
        chk("ovf_no_push",    32'(pushsignal), 32'd0);
        chk("ovf_no_redir",   32'(pc_sel),     32'd0);
        chk("ovf_depth",      32'(depth),      32'd8);
        chk("ovf_idle",       32'(stall),      32'd0);
        call = 1'b1; err_clr = 1'b1;
        tick(); call = 1'b0; err_clr = 1'b0;
        chk("ovf_err_wins",   32'(ovf),        32'd1);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        chk("ovf_cleared",    32'(ovf),        32'd0);

        // Unwind to depth 2
        for (int i = 0; i < 6; i++) begin
            ret = 1'b1;
            tick(); ret = 1'b0;
            tick(); tick(); tick();
        end
        chk("unwind_depth", 32'(depth), 32'd2);

        // Call and return together: return wins, no error
        pop_data = 10'h123; call = 1'b1; ret = 1'b1; pc = 10'h050; target = 10'h300;
        tick(); call = 1'b0; ret = 1'b0;
        chk("prio_popsignal",  32'(popsignal),  32'd1);
        chk("prio_no_push",    32'(pushsignal), 32'd0);
        chk("prio_depth",      32'(depth),      32'd1);
        chk("prio_no_ovf",     32'(ovf),        32'd0);
        tick(); tick();
        chk("prio_pc_next",    32'({pc_sel, pc_next}), 32'({1'b1, 10'h123}));
        tick();

        // Call during WAIT is ignored
        pop_data = 10'h3AA; ret = 1'b1;
        tick(); ret = 1'b0;
        chk("busy_pop", 32'(popsignal), 32'd1);
        tick();
        call = 1'b1; pop_data = 10'h055; pc = 10'h077; target = 10'h111;
        tick(); call = 1'b0;
        chk("busy_no_push",  32'(pushsignal), 32'd0);
        chk("busy_pc_sel",   32'(pc_sel),     32'd1);
        chk("busy_pc_next",  32'(pc_next),    32'h055);
        chk("busy_depth",    32'(depth),      32'd0);
        tick();
        chk("busy_after", 32'({pushsignal, pc_sel, stall, depth}), 32'd0);

        // Return-address wrap
        pc = 10'h3FF; target = 10'h0AA; call = 1'b1;
        tick(); call = 1'b0;
        chk("wrap_push",  32'(push),  32'h000);
        chk("wrap_depth", 32'(depth), 32'd1);
        tick();

        // Asynchronous reset during POP
        ret = 1'b1;
        tick(); ret = 1'b0;
        chk("rstmid_pop", 32'(popsignal), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_outputs", 32'({pushsignal, popsignal, pc_sel, stall, ovf, unf}), 32'd0);
        chk("rstmid_depth",   32'(depth),   32'd0);
        chk("rstmid_pc_next", 32'(pc_next), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstmid_quiet", 32'({pushsignal, popsignal, pc_sel, stall}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/call_ctrl.md
CALL_CTRL -- requirements
Module: call_ctrl

Interface
REQ-001 SHALL have parameter AW, default 10: program-counter and return-address width.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries in the attached return-address stack.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port call, input, 1: subroutine-call request from the decode stage.
REQ-006 SHALL have port ret, input, 1: subroutine-return request from the decode stage.
REQ-007 SHALL have port pc, input, AW: address of the requesting instruction.
REQ-008 SHALL have port target, input, AW: call destination address.
REQ-009 SHALL have port pop_data, input, AW: top-of-stack value returned by the stack after a pop strobe.
REQ-010 SHALL have port err_clr, input, 1: synchronous clear of the sticky error flags.
REQ-011 SHALL have port pushsignal, output, 1: one-cycle push strobe to the stack.
REQ-012 SHALL have port popsignal, output, 1: one-cycle pop strobe to the stack.
REQ-013 SHALL have port push, output, AW: return address to store; valid while pushsignal=1.
REQ-014 SHALL have port pc_sel, output, 1: PC-mux select; 1 loads pc_next into the PC.
REQ-015 SHALL have port pc_next, output, AW: redirect address; valid while pc_sel=1.
REQ-016 SHALL have port stall, output, 1: fetch hold; high whenever the FSM is not IDLE.
REQ-017 SHALL have port depth, output, clog2(DEPTH)+1: current number of occupied stack entries.
REQ-018 SHALL have port ovf, output, 1: sticky flag; a call was attempted at full depth.
REQ-019 SHALL have port unf, output, 1: sticky flag; a return was attempted at zero depth.

Function
REQ-020 SHALL implement a one-hot or encoded FSM with states IDLE, CALL, POP, WAIT and REDIR.
REQ-021 SHALL register every output; no output SHALL depend combinationally on any input.
REQ-022 SHALL, in IDLE, when call=1, ret=0 and depth<DEPTH, go to CALL, register push=pc+1 (mod 2^AW), register pc_next=target and increment depth.
REQ-023 SHALL assert pushsignal=1 and pc_sel=1 for exactly the CALL cycle, then return to IDLE.
REQ-024 SHALL, in IDLE, when ret=1 and depth>0, go to POP and decrement depth.
REQ-025 SHALL assert popsignal=1 for exactly the POP cycle, then go to WAIT.
REQ-026 SHALL, in WAIT, capture pop_data into pc_next at the clock edge leaving WAIT, then go to REDIR.
REQ-027 SHALL assert pc_sel=1 for exactly the REDIR cycle, then return to IDLE.
REQ-028 SHALL give ret priority when call=1 and ret=1 in the same IDLE cycle; the call is discarded with no error.
REQ-029 SHALL ignore call and ret in every state other than IDLE.
REQ-030 SHALL, on a call at depth=DEPTH, set ovf, issue no push and no redirect, and remain in IDLE.
REQ-031 SHALL, on a ret at depth=0, set unf, issue no pop and no redirect, and remain in IDLE.
REQ-032 SHALL clear ovf and unf on err_clr=1; when err_clr and a new error occur in the same cycle, the error SHALL win.
REQ-033 SHALL never assert pushsignal and popsignal in the same cycle.
REQ-034 SHALL keep depth within 0..DEPTH at all times.
REQ-035 SHALL hold stall=0 only in IDLE.
REQ-036 SHALL give call latency as: request sampled at edge N, redirect active in the cycle after N.
REQ-037 SHALL give return latency as: request sampled at edge N, redirect active in the third cycle after N.

Reset
REQ-038 SHALL, while reset=1, immediately force state=IDLE, all outputs to 0 and depth=0, independent of clk.
REQ-039 SHALL abort any in-flight operation on a mid-operation reset; no strobe or redirect SHALL appear after reset deasserts until a new request is sampled.
REQ-040 SHALL begin sampling requests at the first rising clk edge after reset deasserts.

Verification
REQ-041 SHALL verify a single call: pc=0x010, target=0x200, call=1 for one cycle -> next cycle pushsignal=1, push=0x011, pc_sel=1, pc_next=0x200, depth=1.
REQ-042 SHALL verify a single return: depth=1, ret=1, stack drives pop_data=0x011 -> popsignal for 1 cycle, stall for 3 cycles, pc_sel with pc_next=0x011 on the 3rd cycle, depth=0.
REQ-043 SHALL verify overflow: 8 calls, then a 9th call -> ovf=1, no pushsignal, depth=8; err_clr=1 -> ovf=0.
REQ-044 SHALL verify underflow and priority: ret at depth=0 -> unf=1, no popsignal; call+ret together at depth=2 -> return only, depth=1.
REQ-045 SHALL verify wrap and busy-ignore: pc=0x3FF call -> push=0x000; a call issued during WAIT -> ignored, depth unchanged.
REQ-046 SHALL verify reset mid-operation: reset asserted during POP -> all outputs 0 asynchronously; no pc_sel after release.
